// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// PHT indexing modes and the counter value loaded on reset.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  localparam logic [1:0] CTR_RST = WNT;

endpackage

// File: rtl/branch_predictor_btb.sv
// Tagged direct-mapped BTB: combinational lookup port, combinational hit check
// for the resolving PC, synchronous write and valid clear.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  input  logic [XLEN-1:0] upd_pc,
  output logic            upd_hit,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [TW-1:0]      tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];

  logic [IW-1:0] rd_idx, upd_idx;
  logic [TW-1:0] rd_tag, upd_tag;
  logic          unused_low_bits;

  assign rd_idx  = rd_pc[IW+1:2];
  assign rd_tag  = rd_pc[XLEN-1:IW+2];
  assign upd_idx = upd_pc[IW+1:2];
  assign upd_tag = upd_pc[XLEN-1:IW+2];

  // Instructions are word aligned, so the byte offset never reaches the array.
  assign unused_low_bits = ^{rd_pc[1:0], upd_pc[1:0]};

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = rd_hit ? target_q[rd_idx] : '0;
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = wr_target;
    end
  end

  // Only valid bits are reset; tag/target contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB + 2-bit PHT (bimodal or gshare) looked up in
// Fetch, trained and checked for mispredicts when a branch resolves in Execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int HIST_W      = 8,
  parameter int MODE        = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_en,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_vld,
  input  logic            upd_uncond,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mis_cnt
);

  localparam int PHT_IW = $clog2(PHT_ENTRIES);

  logic [1:0]        pht_q [PHT_ENTRIES];
  logic [1:0]        pht_d [PHT_ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       br_cnt_q, br_cnt_d;
  logic [31:0]       mis_cnt_q, mis_cnt_d;

  logic [PHT_IW-1:0] hist_mix, lk_idx, upd_idx;
  logic              lk_hit, upd_hit;
  logic [XLEN-1:0]   lk_target;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  branch_predictor_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (lk_pc),
    .rd_hit    (lk_hit),
    .rd_target (lk_target),
    .upd_pc    (upd_pc),
    .upd_hit   (upd_hit),
    .wr_en     (upd_vld & upd_taken),
    .wr_target (upd_target)
  );

  // Both lookup and training index with the committed history (no speculation).
  assign hist_mix = (MODE == MODE_BIMODAL) ? '0 : PHT_IW'(ghr_q);
  assign lk_idx   = lk_pc[PHT_IW+1:2] ^ hist_mix;
  assign upd_idx  = upd_pc[PHT_IW+1:2] ^ hist_mix;

  assign pred_taken  = pred_en & lk_hit & pht_q[lk_idx][1];
  assign pred_target = lk_target;

  assign mispredict  = upd_vld & ((upd_taken != upd_pred_taken) |
                                  (upd_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

  always_comb begin
    pht_d     = pht_q;
    ghr_d     = ghr_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_vld) begin
      if (upd_uncond)               pht_d[upd_idx] = ST;
      else if (!upd_hit && upd_taken) pht_d[upd_idx] = WT;
      else                          pht_d[upd_idx] = ctr_next(pht_q[upd_idx], upd_taken);
      ghr_d    = (ghr_q << 1) | HIST_W'(upd_taken | upd_uncond);
      br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_RST;
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      pht_q     <= pht_d;
      ghr_q     <= ghr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare predictor share one stimulus stream.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        pred_en;
  logic [31:0] lk_pc;
  logic        upd_vld;
  logic        upd_uncond;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        pred_taken_a, pred_taken_b;
  logic [31:0] pred_target_a, pred_target_b;
  logic        mispredict_a, mispredict_b;
  logic [31:0] redirect_pc_a, redirect_pc_b;
  logic [31:0] br_cnt_a, br_cnt_b;
  logic [31:0] mis_cnt_a, mis_cnt_b;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor #(.XLEN(32), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .HIST_W(8), .MODE(0)) u_bim (
    .clk(clk), .rst(rst), .pred_en(pred_en), .lk_pc(lk_pc),
    .pred_taken(pred_taken_a), .pred_target(pred_target_a),
    .upd_vld(upd_vld), .upd_uncond(upd_uncond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict_a), .redirect_pc(redirect_pc_a),
    .br_cnt(br_cnt_a), .mis_cnt(mis_cnt_a)
  );

  branch_predictor #(.XLEN(32), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .HIST_W(8), .MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .pred_en(pred_en), .lk_pc(lk_pc),
    .pred_taken(pred_taken_b), .pred_target(pred_target_b),
    .upd_vld(upd_vld), .upd_uncond(upd_uncond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict_b), .redirect_pc(redirect_pc_b),
    .br_cnt(br_cnt_b), .mis_cnt(mis_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                           input logic ptaken, input logic [31:0] ptarget, input logic uncond);
    @(negedge clk);
    upd_vld         = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptarget;
    upd_uncond      = uncond;
  endtask

  task automatic idle();
    @(negedge clk);
    upd_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    upd_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lk_pc = 32'h100;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pred_taken: got %0b expected 0", pred_taken_a);
    end
    tests_run++;
    if (pred_target_a !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pred_target: got %0h expected 0", pred_target_a);
    end
    tests_run++;
    if (br_cnt_a !== 32'd0 || mis_cnt_a !== 32'd0) begin
      tests_failed++; $display("FAIL reset_counts: got br=%0d mis=%0d expected 0/0", br_cnt_a, mis_cnt_a);
    end
    tests_run++;
    if (mispredict_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mispredict: got %0b expected 0", mispredict_a);
    end
  endtask

  task automatic test_allocation();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    #1;
    tests_run++;
    if (mispredict_a !== 1'b1 || redirect_pc_a !== 32'h80) begin
      tests_failed++; $display("FAIL alloc_redirect: got mis=%0b pc=%0h expected 1/80", mispredict_a, redirect_pc_a);
    end
    idle();
    lk_pc = 32'h100;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b1 || pred_target_a !== 32'h80) begin
      tests_failed++; $display("FAIL alloc_lookup: got taken=%0b target=%0h expected 1/80", pred_taken_a, pred_target_a);
    end
    tests_run++;
    if (mis_cnt_a !== 32'd1 || br_cnt_a !== 32'd1) begin
      tests_failed++; $display("FAIL alloc_counts: got br=%0d mis=%0d expected 1/1", br_cnt_a, mis_cnt_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
      #1;
      tests_run++;
      if (mispredict_a !== 1'b0) begin
        tests_failed++; $display("FAIL sat_taken_%0d: got mis=%0b expected 0", i, mispredict_a);
      end
    end
    drive_upd(32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 1'b0);
    #1;
    tests_run++;
    if (mispredict_a !== 1'b1) begin
      tests_failed++; $display("FAIL sat_nt1: got mis=%0b expected 1", mispredict_a);
    end
    drive_upd(32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 1'b0);
    #1;
    tests_run++;
    if (mispredict_a !== 1'b1 || redirect_pc_a !== 32'h104) begin
      tests_failed++; $display("FAIL sat_nt2: got mis=%0b pc=%0h expected 1/104", mispredict_a, redirect_pc_a);
    end
    idle();
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b0 || pred_target_a !== 32'h80) begin
      tests_failed++; $display("FAIL sat_weak_nt: got taken=%0b target=%0h expected 0/80", pred_taken_a, pred_target_a);
    end
    tests_run++;
    if (br_cnt_a !== 32'd6 || mis_cnt_a !== 32'd3) begin
      tests_failed++; $display("FAIL sat_counts: got br=%0d mis=%0d expected 6/3", br_cnt_a, mis_cnt_a);
    end
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h80, 1'b0);
    idle();
    pred_en = 1'b1;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b1) begin
      tests_failed++; $display("FAIL pred_en_on: got %0b expected 1", pred_taken_a);
    end
    pred_en = 1'b0;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b0) begin
      tests_failed++; $display("FAIL pred_en_off: got %0b expected 0", pred_taken_a);
    end
    pred_en = 1'b1;
  endtask

  task automatic test_aliasing();
    do_reset();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    drive_upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    idle();
    lk_pc = 32'h100;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b0 || pred_target_a !== 32'h0) begin
      tests_failed++; $display("FAIL alias_old_miss: got taken=%0b target=%0h expected 0/0", pred_taken_a, pred_target_a);
    end
    lk_pc = 32'h200;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b1 || pred_target_a !== 32'h300) begin
      tests_failed++; $display("FAIL alias_new_hit: got taken=%0b target=%0h expected 1/300", pred_taken_a, pred_target_a);
    end
  endtask

  task automatic test_back_to_back();
    drive_upd(32'h200, 1'b1, 32'h340, 1'b1, 32'h300, 1'b0);
    lk_pc = 32'h200;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b1 || pred_target_a !== 32'h300) begin
      tests_failed++; $display("FAIL hazard_same_cycle: got taken=%0b target=%0h expected 1/300", pred_taken_a, pred_target_a);
    end
    idle();
    #1;
    tests_run++;
    if (pred_target_a !== 32'h340) begin
      tests_failed++; $display("FAIL hazard_next_cycle: got %0h expected 340", pred_target_a);
    end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk);
    rst             = 1'b1;
    upd_vld         = 1'b1;
    upd_pc          = 32'h400;
    upd_taken       = 1'b1;
    upd_target      = 32'h480;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
    upd_uncond      = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    upd_vld = 1'b0;
    lk_pc   = 32'h400;
    #1;
    tests_run++;
    if (pred_taken_a !== 1'b0 || pred_target_a !== 32'h0) begin
      tests_failed++; $display("FAIL rst_update_dropped: got taken=%0b target=%0h expected 0/0", pred_taken_a, pred_target_a);
    end
    tests_run++;
    if (br_cnt_a !== 32'd0 || mis_cnt_a !== 32'd0) begin
      tests_failed++; $display("FAIL rst_update_counts: got br=%0d mis=%0d expected 0/0", br_cnt_a, mis_cnt_a);
    end
    lk_pc = 32'h200;
    #1;
    tests_run++;
    if (pred_target_a !== 32'h0) begin
      tests_failed++; $display("FAIL rst_btb_cleared: got %0h expected 0", pred_target_a);
    end
    // Fields held with upd_vld low across an edge must leave state untouched.
    @(negedge clk);
    lk_pc = 32'h400;
    #1;
    tests_run++;
    if (pred_target_a !== 32'h0 || br_cnt_a !== 32'd0) begin
      tests_failed++; $display("FAIL idle_ignored: got target=%0h br=%0d expected 0/0", pred_target_a, br_cnt_a);
    end
  endtask

  task automatic test_target_mismatch();
    do_reset();
    drive_upd(32'h40, 1'b1, 32'h90, 1'b0, 32'h0, 1'b1);
    drive_upd(32'h40, 1'b1, 32'hA0, 1'b1, 32'h90, 1'b1);
    #1;
    tests_run++;
    if (mispredict_b !== 1'b1 || redirect_pc_b !== 32'hA0) begin
      tests_failed++; $display("FAIL jalr_target_redirect: got mis=%0b pc=%0h expected 1/a0", mispredict_b, redirect_pc_b);
    end
    idle();
    lk_pc = 32'h40;
    #1;
    tests_run++;
    if (pred_target_b !== 32'hA0) begin
      tests_failed++; $display("FAIL jalr_target_stored: got %0h expected a0", pred_target_b);
    end
    tests_run++;
    if (pred_taken_a !== 1'b1 || pred_target_a !== 32'hA0) begin
      tests_failed++; $display("FAIL jalr_bimodal_lookup: got taken=%0b target=%0h expected 1/a0", pred_taken_a, pred_target_a);
    end
  endtask

  task automatic test_gshare_alternating();
    logic exp_pred;
    logic exp_mis;
    logic taken;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      taken    = (k % 2 == 0);
      exp_pred = (k >= 10) && (k % 2 == 0);
      exp_mis  = (k <= 8) && (k % 2 == 0);
      drive_upd(32'h80, taken, 32'h200, exp_pred, 32'h200, 1'b0);
      lk_pc = 32'h80;
      #1;
      tests_run++;
      if (pred_taken_b !== exp_pred || mispredict_b !== exp_mis) begin
        tests_failed++;
        $display("FAIL gshare_step_%0d: got pred=%0b mis=%0b expected %0b/%0b", k, pred_taken_b, mispredict_b, exp_pred, exp_mis);
      end
    end
    idle();
    #1;
    tests_run++;
    if (br_cnt_b !== 32'd16 || mis_cnt_b !== 32'd5) begin
      tests_failed++; $display("FAIL gshare_counts: got br=%0d mis=%0d expected 16/5", br_cnt_b, mis_cnt_b);
    end
  endtask

  initial begin
    rst             = 1'b1;
    pred_en         = 1'b1;
    lk_pc           = 32'h0;
    upd_vld         = 1'b0;
    upd_uncond      = 1'b0;
    upd_pc          = 32'h0;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
    repeat (2) @(negedge clk);

    test_reset();
    test_allocation();
    test_saturation();
    test_aliasing();
    test_back_to_back();
    test_reset_mid_update();
    test_target_mismatch();
    test_gshare_alternating();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the next-generation 5-stage RV32I pipeline.
- Lookup is combinational in Fetch and returns a predicted-taken flag and target for pcF.
- Training happens at Execute resolution, which also produces the mispredict/redirect decision that replaces the always-not-taken scheme.
- Holds a tagged BTB, a 2-bit-counter PHT with bimodal or gshare indexing, a global history register, and branch/mispredict performance counters.

Parameters:
- XLEN, 32, data/address width.
- BTB_ENTRIES, 64, BTB entry count; power of two, 4..1024.
- PHT_ENTRIES, 256, PHT counter count; power of two, ≥ BTB_ENTRIES.
- HIST_W, 8, GHR width; must be ≤ log2(PHT_ENTRIES).
- MODE, 0, 0 = bimodal (PHT index from PC only), 1 = gshare (PC XOR GHR).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pred_en  in  1  0 forces pred_taken low; training continues.
- lk_pc  in  XLEN  Fetch PC (pcF).
- pred_taken  out  1  predict taken this cycle.
- pred_target  out  XLEN  predicted target; valid when pred_taken=1.
- upd_vld  in  1  a control-transfer instruction resolves in Execute this cycle.
- upd_uncond  in  1  resolved instruction is jal/jalr.
- upd_pc  in  XLEN  PC of the resolving instruction (pcE).
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target (alu_dataE).
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  redirect required; drives flushD/flushE.
- redirect_pc  out  XLEN  correct next PC.
- br_cnt  out  32  resolved control-transfer count.
- mis_cnt  out  32  mispredict count.

Behaviour:
- Indexing:
  - BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[XLEN-1:log2(BTB_ENTRIES)+2].
  - PHT index = pc[log2(PHT_ENTRIES)+1:2], XOR zero-extended GHR when MODE=1.
- Lookup is fully combinational with zero latency.
  - hit = valid & tag match.
  - pred_taken = pred_en & hit & ctr[1].
  - pred_target = stored target; 0 on a miss.
- mispredict (combinational, upd_vld only) = (upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target).
- redirect_pc = upd_taken ? upd_target : upd_pc+4 (mod 2^XLEN). It is a don't-care when mispredict=0.
- All state updates happen on the clock edge when upd_vld=1. The PHT index uses the GHR value before this update.
- Counter update:
  - taken: ctr = min(ctr+1, 3).
  - not taken: ctr = max(ctr-1, 0).
  - upd_uncond forces ctr = 3.
- BTB hit, taken: overwrite target.
- BTB hit, not taken: target unchanged.
- BTB miss, taken: allocate (direct-mapped replace). Set valid, tag and target, and set PHT ctr = 2 (or 3 if uncond).
- BTB miss, not taken: no allocation; PHT still trained.
- GHR = {GHR[HIST_W-2:0], upd_taken}. Unconditional jumps also shift in 1. The GHR is non-speculative, with no checkpointing.
- Counters:
  - br_cnt += 1 per upd_vld.
  - mis_cnt += 1 per upd_vld & mispredict.
  - Both wrap modulo 2^32.
- Lookup and update to the same entry in the same cycle: lookup returns the pre-update value; the write is visible next cycle.
- Reset (any cycle, including mid-update):
  - all BTB valid = 0;
  - all PHT ctr = 1 (weakly not-taken);
  - GHR = 0; br_cnt = mis_cnt = 0.
  - An update coinciding with rst is dropped.
  - Outputs after reset: pred_taken = 0, pred_target = 0, mispredict = 0 when upd_vld = 0.
- Inputs with upd_vld = 0 are ignored.
- Targets are stored as full XLEN; bits [1:0] are stored as given.

Decomposition:
- Shared package (cpu_def):
  - counter encodings SNT=0, WNT=1, WT=2, ST=3;
  - MODE_BIMODAL / MODE_GSHARE;
  - reset counter value.
- Sub-module bp_btb: tagged direct-mapped valid/tag/target array with combinational read and synchronous write/reset.
- PHT, GHR and counters stay in the top module.

Test Plan:
- Reset defaults: after rst, lookup 0x100 -> pred_taken=0, pred_target=0; br_cnt=mis_cnt=0.
- Allocation: update pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80, mis_cnt=1. Next-cycle lookup 0x100 -> pred_taken=1, pred_target=0x80.
- Counter saturation: three further taken updates at 0x100 -> ctr=3. Two not-taken updates -> ctr=1, lookup pred_taken=0, and the second update reports redirect_pc=0x104. With pred_en=0, taken entry still gives pred_taken=0.
- Tag aliasing (BTB_ENTRIES=64): allocate 0x100, then taken update at 0x200 (same index) -> lookup 0x100 misses, 0x200 hits.
- Target mismatch and gshare (MODE=1):
  - jalr at 0x40 predicted taken to 0x90, actual 0xA0 -> mispredict=1, redirect_pc=0xA0, stored target becomes 0xA0.
  - gshare: alternating T/N pattern at one PC converges to zero mispredicts after warm-up.
- Same-cycle hazard and reset: lookup and update of the same index in one cycle -> old prediction returned. rst asserted with upd_vld=1 -> no allocation; br_cnt=0.
